// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULTU/DIVU engine that borrows the shared
// combinational ALU for one shift-add / shift-subtract step per clock and
// keeps the architectural HI/LO result registers.
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [3:0]       alu_operation_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [4:0]       alu_shamt_o,
    input  logic [WIDTH-1:0] alu_data_i
);

    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOP = 4'b1001;
    localparam int         CW      = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    // acc: product high half (MULTU) or partial remainder (DIVU)
    // shr: multiplier shifting out / product low half (MULTU) or quotient (DIVU)
    // opnd: multiplicand (MULTU) or divisor (DIVU)
    state_t          state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       alu_op_c;
    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_b_c;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] shr_nx;
    logic [WIDTH-1:0] rem_sh;
    logic             carry;
    logic             ge;

    assign rem_sh = {acc_q[WIDTH-2:0], shr_q[WIDTH-1]};

    // One iteration: drive the ALU and form the post-step acc/shr values.
    always_comb begin
        alu_op_c = ALU_NOP;
        alu_a_c  = '0;
        alu_b_c  = '0;
        acc_nx   = acc_q;
        shr_nx   = shr_q;
        carry    = 1'b0;
        ge       = 1'b0;
        if (state_q == S_CALC) begin
            if (is_div_q) begin
                // Restoring division; acc[MSB] set means the shifted value
                // overflowed WIDTH bits and is certainly >= divisor.
                alu_op_c = ALU_SUB;
                alu_a_c  = rem_sh;
                alu_b_c  = opnd_q;
                ge       = acc_q[WIDTH-1] | (rem_sh >= opnd_q);
                acc_nx   = ge ? alu_data_i : rem_sh;
                shr_nx   = {shr_q[WIDTH-2:0], ge};
            end else begin
                // Shift-add multiply; carry-out recovered from unsigned wrap.
                alu_a_c = acc_q;
                if (shr_q[0]) begin
                    alu_op_c = ALU_ADD;
                    alu_b_c  = opnd_q;
                end
                carry  = shr_q[0] && (alu_data_i < acc_q);
                acc_nx = {carry, alu_data_i[WIDTH-1:1]};
                shr_nx = {alu_data_i[0], shr_q[WIDTH-1:1]};
            end
        end
    end

    assign alu_operation_o = alu_op_c;
    assign alu_a_o         = alu_a_c;
    assign alu_b_o         = alu_b_c;
    assign alu_shamt_o     = '0;

    // Next-state and result update; hi/lo only move at completion.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        shr_d    = shr_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !op_i[1]) begin
                    dbz_d    = 1'b0;
                    is_div_d = op_i[0];
                    cnt_d    = '0;
                    acc_d    = '0;
                    if (op_i[0] && (rt_i == '0)) begin
                        state_d = S_DONE;
                        hi_d    = rs_i;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        opnd_d  = op_i[0] ? rt_i : rs_i;
                        shr_d   = op_i[0] ? rs_i : rt_i;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_nx;
                shr_d = shr_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    hi_d    = acc_nx;
                    lo_d    = shr_nx;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; async active-low reset aborts any op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            shr_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            shr_q    <= shr_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: a driver issues MULTU/DIVU requests
// and queues results computed with plain 64-bit arithmetic; a monitor
// compares them whenever done_o pulses and watches idle/hold behaviour.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_i, rt_i;
    logic        busy_o, done_o, div_by_zero_o;
    logic [31:0] hi_o, lo_o;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [4:0]  alu_shamt_o;
    logic [31:0] alu_data_i;

    mdu_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .rs_i(rs_i), .rt_i(rt_i), .busy_o(busy_o), .done_o(done_o),
        .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o),
        .alu_operation_o(alu_operation_o), .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o), .alu_shamt_o(alu_shamt_o), .alu_data_i(alu_data_i)
    );

    // Shared combinational ALU seen by the sequencer.
    always_comb begin
        case (alu_operation_o)
            4'b0011: alu_data_i = alu_a_o + alu_b_o;
            4'b0001: alu_data_i = alu_a_o - alu_b_o;
            4'b1001: alu_data_i = alu_a_o;
            default: alu_data_i = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          issue;
        int          lat;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: result/latency scoreboard plus per-cycle idle and hold rules.
    int          busy_cnt = 0;
    logic [31:0] held_hi = 0, held_lo = 0;
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
        end else begin
            if (busy_o) begin
                busy_cnt++;
                chk("hold_hi", {32'h0, hi_o}, {32'h0, held_hi});
                chk("hold_lo", {32'h0, lo_o}, {32'h0, held_lo});
                chk("dbz_clr", {63'h0, div_by_zero_o}, 64'h0);
            end else begin
                held_hi = hi_o;
                held_lo = lo_o;
                chk("alu_idle", {alu_operation_o, alu_a_o, alu_b_o}, {4'b1001, 64'h0});
            end
            chk("shamt", {59'h0, alu_shamt_o}, 64'h0);
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'h1, 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("hi", {32'h0, hi_o}, {32'h0, e.hi});
                    chk("lo", {32'h0, lo_o}, {32'h0, e.lo});
                    chk("dbz", {63'h0, div_by_zero_o}, {63'h0, e.dbz});
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                end
                busy_cnt = 0;
            end
        end
    end

    // Reference model: plain unsigned arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] rs,
                                   input logic [31:0] rt, input int issue);
        exp_t e;
        logic [63:0] p;
        e.issue = issue;
        e.dbz   = 1'b0;
        e.lat   = 33;
        e.busy  = 32;
        if (op[0] == 1'b0) begin
            p    = 64'(rs) * 64'(rt);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (rt == 0) begin
            e.hi  = rs;
            e.lo  = 32'hFFFFFFFF;
            e.dbz = 1'b1;
            e.lat = 1;
            e.busy = 0;
        end else begin
            e.hi = rs % rt;
            e.lo = rs / rt;
        end
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy_o || done_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 64'h1, 64'h0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input bit hold);
        logic [31:0] hi0, lo0;
        int n;
        wait_idle();
        hi0 = hi_o;
        lo0 = lo_o;
        start_i = 1'b1;
        op_i    = op;
        rs_i    = rs;
        rt_i    = rt;
        if (!op[1]) exp_q.push_back(model(op, rs, rt, cyc));
        @(negedge clk);
        start_i = hold;
        op_i    = 2'($urandom);
        rs_i    = $urandom;
        rt_i    = $urandom;
        if (op[1]) begin
            chk("rsvd_busy", {62'h0, busy_o, done_o}, 64'h0);
            chk("rsvd_hilo", {hi_o, lo_o}, {hi0, lo0});
            start_i = 1'b0;
        end else begin
            n = 0;
            while (!done_o && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk("done_timeout", 64'h1, 64'h0);
            start_i = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] rs, rt;
        int          n;
        reset   = 1'b0;
        start_i = 1'b0;
        op_i    = 2'b00;
        rs_i    = 32'h0;
        rt_i    = 32'h0;
        #1;
        chk("rst_flags", {61'h0, busy_o, done_o, div_by_zero_o}, 64'h0);
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        chk("rst_alu", {alu_operation_o, alu_a_o, alu_b_o}, {4'b1001, 64'h0});
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed cases, including carry, R[31] and divide-by-zero paths.
        issue(2'b00, 32'd7, 32'd6, 1'b0);
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(2'b01, 32'd100, 32'd7, 1'b0);
        issue(2'b01, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        issue(2'b01, 32'd5, 32'd0, 1'b0);
        issue(2'b00, 32'd3, 32'd4, 1'b0);
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        issue(2'b10, 32'd9, 32'd9, 1'b0);
        issue(2'b11, 32'd9, 32'd0, 1'b0);
        issue(2'b01, 32'hDEADBEEF, 32'd1, 1'b1);

        // Reset asserted in the middle of a MULTU.
        wait_idle();
        start_i = 1'b1;
        op_i    = 2'b00;
        rs_i    = 32'hCAFEF00D;
        rt_i    = 32'h0BADBEEF;
        exp_q.push_back(model(2'b00, rs_i, rt_i, cyc));
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_flags", {61'h0, busy_o, done_o, div_by_zero_o}, 64'h0);
        chk("abort_hilo", {hi_o, lo_o}, 64'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_idle", {62'h0, busy_o, done_o}, 64'h0);
        end

        // Random operations.
        for (int i = 0; i < 1000; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            rs = $urandom;
            case ($urandom_range(0, 3))
                0:       rt = 32'h0;
                1:       rt = 32'($urandom_range(1, 255));
                default: rt = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 1000));
            issue(op, rs, rt, $urandom_range(0, 7) == 0);
        end

        n = 0;
        while ((exp_q.size() != 0 || busy_o || done_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
